// File: rtl/phy_pkg.sv
// Shared PHY definitions: pattern mode encodings, generator FSM states and
// 8b/10b K-code control characters used on the transmit lanes.
package phy_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED   = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_COUNT   = 2'd2,
    MODE_PRBS    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } gen_state_e;

  localparam logic [7:0] CODE_COM = 8'hBC;  // K28.5 comma
  localparam logic [7:0] CODE_IDL = 8'h7C;  // K28.3
  localparam logic [7:0] CODE_FTS = 8'h3C;  // K28.1
  localparam logic [7:0] CODE_BD  = 8'hBD;

  localparam logic [7:0] DEFAULT_IDLE_CODE = CODE_COM;

endpackage

// File: rtl/phy_prbs_step.sv
// One combinational step of a right-shifting Galois LFSR.
module phy_prbs_step #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] PRBS_POLY = 8'hB8
) (
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] nxt
);

  assign nxt = (cur >> 1) ^ (cur[0] ? PRBS_POLY : '0);

endmodule

// File: rtl/phy_lane_pattern_gen.sv
// Multi-lane burst/gap pattern source for the PHY tx path: fixed, checkerboard,
// counting and PRBS words, each held HOLD_CYCLES clocks, with run control.
module phy_lane_pattern_gen
  import phy_pkg::*;
#(
  parameter int                NUM_LANES   = 4,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] IDLE_CODE   = DEFAULT_IDLE_CODE,
  parameter int                HOLD_CYCLES = 11,
  parameter int                CNT_W       = 16,
  parameter logic [DATA_W-1:0] PRBS_POLY   = 8'hB8
) (
  input  logic                        clk_32f,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        continuous,
  input  logic [1:0]                  mode,
  input  logic [CNT_W-1:0]            burst_len,
  input  logic [CNT_W-1:0]            gap_len,
  input  logic [DATA_W-1:0]           seed,
  output logic [NUM_LANES*DATA_W-1:0] data_out,
  output logic [NUM_LANES-1:0]        valid_out,
  output logic [DATA_W-1:0]           idle_out,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            word_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [NUM_LANES*DATA_W-1:0] IDLE_WORD = {NUM_LANES{IDLE_CODE}};

  gen_state_e          state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]    burst_idx, gap_idx, burst_q, gap_q;
  logic                cont_q;
  mode_e               mode_q;

  // Generator state describing the next word to be emitted
  logic [DATA_W-1:0]   base_q, lfsr_q;
  logic                ph_q;

  mode_e                       gen_mode;
  logic [DATA_W-1:0]           gen_base, gen_lfsr, nxt_base;
  logic                        gen_ph;
  logic [NUM_LANES*DATA_W-1:0] gen_word;
  logic [DATA_W-1:0]           chain [NUM_LANES+1];

  logic word_end, burst_last, gap_last, start_ok, stop_hit, load_word;

  assign idle_out = IDLE_CODE;

  // While idle the generator previews word 0 straight from the inputs
  always_comb begin
    if (state == ST_IDLE) begin
      gen_mode = mode_e'(mode);
      gen_base = seed;
      gen_ph   = 1'b0;
      gen_lfsr = (seed == '0) ? DATA_W'(1) : seed;
    end else begin
      gen_mode = mode_q;
      gen_base = base_q;
      gen_ph   = ph_q;
      gen_lfsr = lfsr_q;
    end
  end

  // Lane i carries the LFSR state after i steps; the word consumes NUM_LANES steps
  assign chain[0] = gen_lfsr;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_prbs
    phy_prbs_step #(
      .DATA_W    (DATA_W),
      .PRBS_POLY (PRBS_POLY)
    ) u_step (
      .cur (chain[g]),
      .nxt (chain[g+1])
    );
  end

  always_comb begin
    gen_word = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (gen_mode)
        MODE_FIXED:   gen_word[i*DATA_W +: DATA_W] = gen_base;
        MODE_CHECKER: gen_word[i*DATA_W +: DATA_W] = ((i % 2 == 0) ^ gen_ph) ? '1 : '0;
        MODE_COUNT:   gen_word[i*DATA_W +: DATA_W] = gen_base + DATA_W'(i);
        default:      gen_word[i*DATA_W +: DATA_W] = chain[i];
      endcase
    end
    nxt_base = (gen_mode == MODE_COUNT) ? gen_base + DATA_W'(NUM_LANES) : gen_base;
  end

  always_comb begin
    word_end   = (hold_cnt == HOLD_LAST);
    burst_last = (burst_idx == burst_q - 1'b1);
    gap_last   = (gap_idx == gap_q - 1'b1);
    start_ok   = start && !stop && (burst_len != '0);
    stop_hit   = stop && busy;
    load_word  = 1'b0;
    case (state)
      ST_IDLE: load_word = start_ok;
      ST_SEND: load_word = word_end && (!burst_last || (gap_q == '0 && cont_q));
      ST_GAP:  load_word = word_end && gap_last && cont_q;
      default: load_word = 1'b0;
    endcase
    if (stop_hit) load_word = 1'b0;
  end

  always_ff @(posedge clk_32f or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      data_out   <= IDLE_WORD;
      valid_out  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      hold_cnt   <= '0;
      burst_idx  <= '0;
      gap_idx    <= '0;
      burst_q    <= '0;
      gap_q      <= '0;
      cont_q     <= 1'b0;
      mode_q     <= MODE_FIXED;
      base_q     <= '0;
      lfsr_q     <= '0;
      ph_q       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop_hit) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        data_out  <= IDLE_WORD;
        valid_out <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              state      <= ST_SEND;
              busy       <= 1'b1;
              word_count <= '0;
              hold_cnt   <= '0;
              burst_idx  <= '0;
              mode_q     <= mode_e'(mode);
              burst_q    <= burst_len;
              gap_q      <= gap_len;
              cont_q     <= continuous;
            end
          end
          ST_SEND, ST_GAP: begin
            hold_cnt <= word_end ? '0 : hold_cnt + 1'b1;
            if (word_end && state == ST_SEND) begin
              if (word_count != '1) word_count <= word_count + 1'b1;
              burst_idx <= burst_last ? '0 : burst_idx + 1'b1;
              if (burst_last && gap_q != '0) begin
                state     <= ST_GAP;
                gap_idx   <= '0;
                data_out  <= IDLE_WORD;
                valid_out <= '0;
              end else if (burst_last && !cont_q) begin
                state     <= ST_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                data_out  <= IDLE_WORD;
                valid_out <= '0;
              end
            end else if (word_end) begin
              gap_idx <= gap_idx + 1'b1;
              if (gap_last && cont_q) begin
                state <= ST_SEND;
              end else if (gap_last) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
        if (load_word) begin
          data_out  <= gen_word;
          valid_out <= '1;
          base_q    <= nxt_base;
          ph_q      <= ~gen_ph;
          lfsr_q    <= chain[NUM_LANES];
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_lane_pattern_gen.sv
// Bench for phy_lane_pattern_gen: a run-level model expands each accepted start
// into the expected per-cycle output sequence, checked on every clock.
module tb_phy_lane_pattern_gen;

  localparam int          HOLD   = 11;
  localparam logic [31:0] IDLE32 = 32'hBCBCBCBC;

  logic        clk_32f = 1'b0;
  logic        rst, start, stop, continuous;
  logic [1:0]  mode;
  logic [15:0] burst_len, gap_len;
  logic [7:0]  seed;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic [7:0]  idle_out;
  logic        busy, done;
  logic [15:0] word_count;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  v;
    logic        b;
    logic        dn;
    logic [15:0] wc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  phy_lane_pattern_gen dut (
    .clk_32f    (clk_32f),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mode       (mode),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .seed       (seed),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .idle_out   (idle_out),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk_32f = ~clk_32f;

  function automatic logic [7:0] lfsr_step(logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  // Word w of a run, straight from the pattern definitions
  function automatic logic [31:0] pat_word(int md, logic [7:0] sd, int w);
    logic [31:0] r;
    logic [7:0]  s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (md)
        0: r[i*8 +: 8] = sd;
        1: r[i*8 +: 8] = (((i % 2) == 0) != ((w % 2) == 1)) ? 8'hFF : 8'h00;
        2: r[i*8 +: 8] = 8'(int'(sd) + w * 4 + i);
        default: begin
          s = (sd == 8'h00) ? 8'h01 : sd;
          for (int k = 0; k < w * 4 + i; k++) s = lfsr_step(s);
          r[i*8 +: 8] = s;
        end
      endcase
    end
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic build(int md, int bl, int gl, bit cont, logic [7:0] sd);
    exp_t e;
    int   w;
    w = 0;
    e.wc = '0;
    q.delete();
    do begin
      for (int k = 0; k < bl; k++) begin
        for (int h = 0; h < HOLD; h++) begin
          e.d = pat_word(md, sd, w); e.v = 4'hF; e.b = 1'b1; e.dn = 1'b0;
          q.push_back(e);
        end
        w++;
        e.wc = e.wc + 16'd1;
      end
      for (int k = 0; k < gl * HOLD; k++) begin
        e.d = IDLE32; e.v = 4'h0; e.b = 1'b1; e.dn = 1'b0;
        q.push_back(e);
      end
    end while (cont && q.size() < 700);
    if (!cont) begin
      e.d = IDLE32; e.v = 4'h0; e.b = 1'b0; e.dn = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic model_edge();
    if (!rst) return;
    if (stop && cur.b) q.delete();
    else if (!cur.b && !cur.dn && start && !stop && burst_len != 16'd0)
      build(int'(mode), int'(burst_len), int'(gap_len), continuous, seed);
  endtask

  task automatic set_idle(logic [15:0] wc);
    cur.d = IDLE32; cur.v = 4'h0; cur.b = 1'b0; cur.dn = 1'b0; cur.wc = wc;
  endtask

  task automatic compare();
    if (q.size() > 0) cur = q.pop_front();
    else set_idle(cur.wc);
    check("data_out",   data_out,          cur.d);
    check("valid_out",  32'(valid_out),    32'(cur.v));
    check("busy",       32'(busy),         32'(cur.b));
    check("done",       32'(done),         32'(cur.dn));
    check("word_count", 32'(word_count),   32'(cur.wc));
    check("idle_out",   32'(idle_out),     32'h000000BC);
  endtask

  task automatic tick();
    @(posedge clk_32f);
    model_edge();
    @(negedge clk_32f);
    compare();
  endtask

  task automatic go(logic [1:0] md, logic [7:0] sd, logic [15:0] bl, logic [15:0] gl, logic ct);
    mode = md; seed = sd; burst_len = bl; gap_len = gl; continuous = ct; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    mode = 2'd0; burst_len = '0; gap_len = '0; seed = '0;
    set_idle(16'd0);

    check("model_count_w0", pat_word(2, 8'hFE, 0), 32'h0100FFFE);
    check("model_prbs_w0",  pat_word(3, 8'h00, 0), 32'h2E5CB801);
    check("model_prbs_w1",  pat_word(3, 8'h00, 1), 32'hC8E1B317);

    #1 rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // FIXED burst with one gap word; a start during the burst must be ignored
    go(2'd0, 8'hAA, 16'd2, 16'd1, 1'b0);
    check("fixed_w0", data_out, 32'hAAAAAAAA);
    repeat (3) tick();
    start = 1'b1; burst_len = 16'd5; seed = 8'h55;
    tick();
    start = 1'b0;
    repeat (17) tick();
    check("fixed_last", data_out, 32'hAAAAAAAA);
    tick();
    check("fixed_gap", data_out, IDLE32);
    check("fixed_gap_vld", 32'(valid_out), 32'h0);
    repeat (11) tick();
    check("fixed_done", 32'(done), 32'h1);
    check("fixed_wc", 32'(word_count), 32'd2);
    tick();

    // CHECKER, no gap
    go(2'd1, 8'h00, 16'd3, 16'd0, 1'b0);
    check("chk_w0", data_out, 32'h00FF00FF);
    repeat (11) tick();
    check("chk_w1", data_out, 32'hFF00FF00);
    repeat (11) tick();
    check("chk_w2", data_out, 32'h00FF00FF);
    repeat (11) tick();
    check("chk_done", 32'(done), 32'h1);
    tick();

    // COUNT wraps mod 256
    go(2'd2, 8'hFE, 16'd2, 16'd0, 1'b0);
    check("cnt_w0", data_out, 32'h0100FFFE);
    repeat (11) tick();
    check("cnt_w1", data_out, 32'h05040302);
    repeat (11) tick();
    check("cnt_done", 32'(done), 32'h1);
    tick();

    // Control corners
    go(2'd0, 8'h11, 16'd0, 16'd0, 1'b0);
    check("bl0_ignored", 32'(busy), 32'h0);
    stop = 1'b1;
    go(2'd0, 8'h11, 16'd2, 16'd0, 1'b0);
    stop = 1'b0;
    check("start_stop_idle", 32'(busy), 32'h0);
    tick();

    // PRBS, continuous, seed 0 forced to 1, stopped during word 5
    go(2'd3, 8'h00, 16'd3, 16'd2, 1'b1);
    check("prbs_w0", data_out, 32'h2E5CB801);
    repeat (11) tick();
    check("prbs_w1", data_out, 32'hC8E1B317);
    repeat (68) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0; continuous = 1'b0;
    check("prbs_stop_busy", 32'(busy), 32'h0);
    check("prbs_stop_done", 32'(done), 32'h0);
    check("prbs_stop_wc", 32'(word_count), 32'd5);
    repeat (3) tick();

    // Asynchronous reset during SEND
    go(2'd0, 8'h5A, 16'd4, 16'd0, 1'b0);
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    check("arst_data", data_out, IDLE32);
    check("arst_valid", 32'(valid_out), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    q.delete();
    set_idle(16'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
